nitta_i2c_tx_controller: RTL and testbench

- Sequences outgoing NITTA words onto the I2C byte engine. Buffers up to DEPTH full-width words written by the NITTA side and serves them one byte at a time, MSB-first.
- Frames transactions with a last-byte flag and aborts/flushes on slave NACK.
- Sits between the NITTA I2C processing unit and the I2C byte-level transmitter; it replaces the free-running word splitter with a buffered, NACK-aware sequencer.

---
 rtl/nitta_i2c_pkg.sv | 32 +++
 rtl/nitta_i2c_tx_controller_if.sv | 32 +++
 rtl/nitta_i2c_word_fifo.sv | 75 +++++++
 rtl/nitta_i2c_tx_controller.sv | 125 ++++++++++++
 tb/tb_nitta_i2c_tx_controller.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/nitta_i2c_pkg.sv
// Shared types and sizing helpers for the NITTA I2C transmit path.
// Holds the sequencer state encoding and the word-to-byte slicing rule.
package nitta_i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_ABORT = 2'd2
    } state_e;

    function automatic int bytes_per_word(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Byte 0 is the most significant byte of the word.
    function automatic int byte_lsb(input int idx, input int data_w, input int byte_w);
        return data_w - (idx + 1) * byte_w;
    endfunction

endpackage

// File: rtl/nitta_i2c_tx_controller_if.sv
// NITTA-side word port and I2C byte-engine port of the transmit sequencer.
// slave is the sequencer's view; master is the view of whoever drives it.
interface nitta_i2c_tx_controller_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int DEPTH          = 4
);
    logic                                         nitta_wr;
    logic [DATA_WIDTH-1:0]                        nitta_data;
    logic                                         nitta_full;
    logic [nitta_i2c_pkg::cnt_width(DEPTH)-1:0]   buf_count;
    logic [I2C_DATA_WIDTH-1:0]                    to_i2c;
    logic                                         i2c_valid;
    logic                                         i2c_last;
    logic                                         i2c_ack;
    logic                                         i2c_nack;
    logic                                         word_done;
    logic                                         abort;
    logic                                         overflow;

    modport slave (
        input  nitta_wr, nitta_data, i2c_ack, i2c_nack,
        output nitta_full, buf_count, to_i2c, i2c_valid, i2c_last,
               word_done, abort, overflow
    );

    modport master (
        output nitta_wr, nitta_data, i2c_ack, i2c_nack,
        input  nitta_full, buf_count, to_i2c, i2c_valid, i2c_last,
               word_done, abort, overflow
    );
endinterface

// File: rtl/nitta_i2c_word_fifo.sv
// Circular word buffer: push/pop in one cycle, head word readable combinationally.
// Push while full without a same-cycle pop is dropped and latches a sticky overflow.
module nitta_i2c_word_fifo
    import nitta_i2c_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic [DATA_WIDTH-1:0]          i_data,
    input  logic                           i_pop,
    input  logic                           i_flush,
    output logic [DATA_WIDTH-1:0]          o_head,
    output logic [cnt_width(DEPTH)-1:0]    o_count,
    output logic                           o_full,
    output logic                           o_overflow
);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  w_full;
    logic                  w_push_ok;

    assign w_full    = (r_count == CW'(DEPTH));
    // A pop in the same cycle frees the slot the push needs; a flush wins over both.
    assign w_push_ok = i_push && !i_flush && (!w_full || i_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_tail] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_flush) begin
                r_head  <= r_tail;
                r_count <= '0;
            end else begin
                if (w_push_ok) begin
                    r_tail <= r_tail + PW'(1);
                end
                if (i_pop) begin
                    r_head <= r_head + PW'(1);
                end
                case ({w_push_ok, i_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
            if (i_push && !i_flush && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_head     = r_mem[r_head];
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/nitta_i2c_tx_controller.sv
// Buffers NITTA words and serves them MSB-first to the I2C byte engine; first byte 2 edges after write.
// Bytes advance on i2c_ack with no bubbles; NACK flushes the buffer and pulses abort.
module nitta_i2c_tx_controller
    import nitta_i2c_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int DEPTH          = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    nitta_i2c_tx_controller_if.slave   bus
);
    localparam int BYTES = bytes_per_word(DATA_WIDTH, I2C_DATA_WIDTH);
    localparam int IW    = idx_width(BYTES);
    localparam int CW    = cnt_width(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic [IW-1:0]             r_byte_idx;
    logic [IW-1:0]             w_byte_idx_nxt;
    logic                      r_word_done;
    logic                      w_word_done_nxt;
    logic                      r_abort;
    logic                      w_abort_nxt;
    logic                      w_pop;
    logic                      w_flush;
    logic                      w_send;
    logic                      w_last_byte;
    logic [DATA_WIDTH-1:0]     w_head;
    logic [CW-1:0]             w_count;
    logic                      w_full;
    logic                      w_overflow;
    logic [I2C_DATA_WIDTH-1:0] w_bytes [BYTES];

    nitta_i2c_word_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (bus.nitta_wr),
        .i_data     (bus.nitta_data),
        .i_pop      (w_pop),
        .i_flush    (w_flush),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_overflow (w_overflow)
    );

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_slice
        assign w_bytes[gi] = w_head[byte_lsb(gi, DATA_WIDTH, I2C_DATA_WIDTH) +: I2C_DATA_WIDTH];
    end

    assign w_send      = (r_state == ST_SEND);
    assign w_last_byte = (r_byte_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_byte_idx  <= '0;
            r_word_done <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_word_done <= w_word_done_nxt;
            r_abort     <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_byte_idx_nxt  = r_byte_idx;
        w_word_done_nxt = 1'b0;
        w_abort_nxt     = 1'b0;
        w_pop           = 1'b0;
        w_flush         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_count != '0) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.i2c_nack) begin
                    w_flush        = 1'b1;
                    w_byte_idx_nxt = '0;
                    w_abort_nxt    = 1'b1;
                    w_state_nxt    = ST_ABORT;
                end else if (bus.i2c_ack) begin
                    if (w_last_byte) begin
                        w_pop           = 1'b1;
                        w_byte_idx_nxt  = '0;
                        w_word_done_nxt = 1'b1;
                        // A write landing with the final pop keeps the buffer non-empty.
                        if (w_count == CW'(1) && !bus.nitta_wr) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + IW'(1);
                    end
                end
            end
            ST_ABORT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.to_i2c     = w_send ? w_bytes[r_byte_idx] : '0;
    assign bus.i2c_valid  = w_send;
    assign bus.i2c_last   = w_send && w_last_byte && (w_count == CW'(1));
    assign bus.word_done  = r_word_done;
    assign bus.abort      = r_abort;
    assign bus.nitta_full = w_full;
    assign bus.buf_count  = w_count;
    assign bus.overflow   = w_overflow;

endmodule

// File: tb/tb_nitta_i2c_tx_controller.sv
// Directed vector bench for the NITTA I2C transmit sequencer.
module tb_nitta_i2c_tx_controller;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    nitta_i2c_tx_controller_if #(.DATA_WIDTH(32), .I2C_DATA_WIDTH(8), .DEPTH(4)) bus ();

    nitta_i2c_tx_controller #(
        .DATA_WIDTH     (32),
        .I2C_DATA_WIDTH (8),
        .DEPTH          (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        logic        ack;
        logic        nack;
        logic        vld;
        logic [7:0]  byt;
        logic        last;
        logic        done;
        logic        abrt;
        logic [2:0]  cnt;
        logic        full;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic wr, input logic [31:0] data, input logic ack, input logic nack,
                     input logic vld, input logic [7:0] byt, input logic last, input logic done,
                     input logic abrt, input logic [2:0] cnt, input logic full, input logic ovf);
        vec_t t;
        t.wr = wr; t.data = data; t.ack = ack; t.nack = nack;
        t.vld = vld; t.byt = byt; t.last = last; t.done = done;
        t.abrt = abrt; t.cnt = cnt; t.full = full; t.ovf = ovf;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [31:0] data, input logic ack, input logic nack);
        bus.nitta_wr   = wr;
        bus.nitta_data = data;
        bus.i2c_ack    = ack;
        bus.i2c_nack   = nack;
    endtask

    task automatic chk_outputs(input string tag, input logic vld, input logic [7:0] byt,
                               input logic last, input logic done, input logic abrt,
                               input logic [2:0] cnt, input logic full, input logic ovf);
        chk({tag, ".i2c_valid"},  32'(bus.i2c_valid),  32'(vld));
        chk({tag, ".to_i2c"},     32'(bus.to_i2c),     32'(byt));
        chk({tag, ".i2c_last"},   32'(bus.i2c_last),   32'(last));
        chk({tag, ".word_done"},  32'(bus.word_done),  32'(done));
        chk({tag, ".abort"},      32'(bus.abort),      32'(abrt));
        chk({tag, ".buf_count"},  32'(bus.buf_count),  32'(cnt));
        chk({tag, ".nitta_full"}, 32'(bus.nitta_full), 32'(full));
        chk({tag, ".overflow"},   32'(bus.overflow),   32'(ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // single word, acks spaced out
        v(1, 32'hA0B1C2D3, 0, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        0, 0,  1, 8'hA0, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        0, 0,  1, 8'hA0, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'hB1, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        0, 0,  1, 8'hB1, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'hC2, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        0, 0,  1, 8'hC2, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'hD3, 1, 0, 0, 1, 0, 0);
        v(0, 32'h0,        0, 0,  1, 8'hD3, 1, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  0, 8'h00, 0, 1, 0, 0, 0, 0);
        v(0, 32'h0,        0, 0,  0, 8'h00, 0, 0, 0, 0, 0, 0);
        // back-to-back words, ack held high (ignored while idle)
        v(1, 32'h11223344, 0, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0);
        v(1, 32'h55667788, 1, 0,  1, 8'h11, 0, 0, 0, 2, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'h22, 0, 0, 0, 2, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'h33, 0, 0, 0, 2, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'h44, 0, 0, 0, 2, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'h55, 0, 1, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'h66, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'h77, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'h88, 1, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  0, 8'h00, 0, 1, 0, 0, 0, 0);
        v(0, 32'h0,        0, 0,  0, 8'h00, 0, 0, 0, 0, 0, 0);
        // write together with the final-byte ack
        v(1, 32'h12345678, 0, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        0, 0,  1, 8'h12, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'h34, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'h56, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'h78, 1, 0, 0, 1, 0, 0);
        v(1, 32'hCAFEF00D, 1, 0,  1, 8'hCA, 0, 1, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'hFE, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'hF0, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'h0D, 1, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  0, 8'h00, 0, 1, 0, 0, 0, 0);
        v(0, 32'h0,        0, 0,  0, 8'h00, 0, 0, 0, 0, 0, 0);
        // NACK on the second byte; write in the NACK cycle is dropped silently
        v(1, 32'hA0B1C2D3, 0, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0);
        v(1, 32'h11223344, 0, 0,  1, 8'hA0, 0, 0, 0, 2, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'hB1, 0, 0, 0, 2, 0, 0);
        v(1, 32'h99999999, 0, 1,  0, 8'h00, 0, 0, 1, 0, 0, 0);
        v(1, 32'hDEADBEEF, 0, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        0, 0,  1, 8'hDE, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'hAD, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'hBE, 0, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  1, 8'hEF, 1, 0, 0, 1, 0, 0);
        v(0, 32'h0,        1, 0,  0, 8'h00, 0, 1, 0, 0, 0, 0);
        v(0, 32'h0,        1, 1,  0, 8'h00, 0, 0, 0, 0, 0, 0);
        // fill past DEPTH, then drain
        v(1, 32'h01020304, 0, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0);
        v(1, 32'h05060708, 0, 0,  1, 8'h01, 0, 0, 0, 2, 0, 0);
        v(1, 32'h090A0B0C, 0, 0,  1, 8'h01, 0, 0, 0, 3, 0, 0);
        v(1, 32'h0D0E0F10, 0, 0,  1, 8'h01, 0, 0, 0, 4, 1, 0);
        v(1, 32'hFFFFFFFF, 0, 0,  1, 8'h01, 0, 0, 0, 4, 1, 1);
        v(0, 32'h0,        0, 0,  1, 8'h01, 0, 0, 0, 4, 1, 1);
        v(0, 32'h0,        1, 0,  1, 8'h02, 0, 0, 0, 4, 1, 1);
        v(0, 32'h0,        1, 0,  1, 8'h03, 0, 0, 0, 4, 1, 1);
        v(0, 32'h0,        1, 0,  1, 8'h04, 0, 0, 0, 4, 1, 1);
        v(0, 32'h0,        1, 0,  1, 8'h05, 0, 1, 0, 3, 0, 1);
        v(0, 32'h0,        1, 0,  1, 8'h06, 0, 0, 0, 3, 0, 1);
        v(0, 32'h0,        1, 0,  1, 8'h07, 0, 0, 0, 3, 0, 1);
        v(0, 32'h0,        1, 0,  1, 8'h08, 0, 0, 0, 3, 0, 1);
        v(0, 32'h0,        1, 0,  1, 8'h09, 0, 1, 0, 2, 0, 1);
        v(0, 32'h0,        1, 0,  1, 8'h0A, 0, 0, 0, 2, 0, 1);
        v(0, 32'h0,        1, 0,  1, 8'h0B, 0, 0, 0, 2, 0, 1);
        v(0, 32'h0,        1, 0,  1, 8'h0C, 0, 0, 0, 2, 0, 1);
        v(0, 32'h0,        1, 0,  1, 8'h0D, 0, 1, 0, 1, 0, 1);
        v(0, 32'h0,        1, 0,  1, 8'h0E, 0, 0, 0, 1, 0, 1);
        v(0, 32'h0,        1, 0,  1, 8'h0F, 0, 0, 0, 1, 0, 1);
        v(0, 32'h0,        1, 0,  1, 8'h10, 1, 0, 0, 1, 0, 1);
        v(0, 32'h0,        1, 0,  0, 8'h00, 0, 1, 0, 0, 0, 1);
        v(0, 32'h0,        0, 0,  0, 8'h00, 0, 0, 0, 0, 0, 1);

        repeat (2) @(negedge clk);
        chk_outputs("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wr, vecs[i].data, vecs[i].ack, vecs[i].nack);
            @(negedge clk);
            chk_outputs($sformatf("vec%0d", i), vecs[i].vld, vecs[i].byt, vecs[i].last,
                        vecs[i].done, vecs[i].abrt, vecs[i].cnt, vecs[i].full, vecs[i].ovf);
        end

        // async reset while the engine is on the third byte
        drive(1'b1, 32'hA0B1C2D3, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h55555555, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk_outputs("pre_rst", 1'b1, 8'hC2, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1);
        #2 rst = 1'b0;
        #1 chk_outputs("in_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 32'hA0B1C2D3, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk_outputs("post_rst_wr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        @(negedge clk);
        chk_outputs("post_rst_a0", 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
